// File: rtl/seg7_scan_ctrl.sv
// Four-digit time-multiplexed 7-segment scan controller sharing one external BCD decoder.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN (suppress leading zeros on digits 1..3).
//
// state | meaning
// SHOW  | one anode asserted, decoder pattern (one-cycle registered) on the bus
// BLANK | all anodes off, bus dark; dead time between digits
module seg7_scan_ctrl #(
  parameter int PRESCALE    = 50000,
  parameter int DEAD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic [3:0] bcd,
  input  logic [6:0] seg7_in,
  output logic [6:0] seg7,
  output logic [3:0] an,
  output logic [1:0] scan_idx
);

  localparam logic SHOW  = 1'b0;
  localparam logic BLANK = 1'b1;

  localparam logic [19:0] SHOW_LAST  = 20'(PRESCALE - 1);
  localparam logic [19:0] BLANK_LAST = 20'(DEAD_CYCLES - 1);
  localparam logic [6:0]  SEG_OFF    = 7'b1111111;

  logic        state;
  logic [19:0] cnt;
  logic [3:0]  digit [4];
  logic [6:0]  seg7_q;
  logic        lz_hide;
  logic        hide;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) digit[i] <= 4'd0;
    end else if (wr_en) begin
      digit[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SHOW;
      cnt      <= 20'd0;
      scan_idx <= 2'd0;
    end else begin
      case (state)
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state <= BLANK;
            cnt   <= 20'd0;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        default: begin
          if (cnt == BLANK_LAST) begin
            state    <= SHOW;
            cnt      <= 20'd0;
            scan_idx <= scan_idx + 2'd1;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
      endcase
    end
  end

  assign bcd = digit[scan_idx];

  always_comb begin
    lz_hide = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    case (scan_idx)
      2'd1:    lz_hide = (digit[1] == 4'd0) && (digit[2] == 4'd0) && (digit[3] == 4'd0);
      2'd2:    lz_hide = (digit[2] == 4'd0) && (digit[3] == 4'd0);
      2'd3:    lz_hide = (digit[3] == 4'd0);
      default: lz_hide = 1'b0;
    endcase
`else
    lz_hide = 1'b0;
`endif
  end

  assign hide = (bcd > 4'd9) || lz_hide;

  // Register stays dark through BLANK so the first SHOW cycle never carries the previous digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg7_q <= SEG_OFF;
    end else if (state == SHOW && !hide) begin
      seg7_q <= seg7_in;
    end else begin
      seg7_q <= SEG_OFF;
    end
  end

  assign seg7 = (state == SHOW) ? seg7_q : SEG_OFF;
  assign an   = (state == SHOW) ? ~(4'b0001 << scan_idx) : 4'b1111;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with PRESCALE=8, DEAD_CYCLES=2 and a behavioural BCD decoder.
module tb_seg7_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] bcd;
  logic [6:0] seg7_in;
  logic [6:0] seg7;
  logic [3:0] an;
  logic [1:0] scan_idx;

  int errors = 0;
  int checks = 0;

  seg7_scan_ctrl #(.PRESCALE(8), .DEAD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .bcd(bcd), .seg7_in(seg7_in), .seg7(seg7), .an(an), .scan_idx(scan_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: dec = 7'b1000000;
      4'd1: dec = 7'b1111001;
      4'd2: dec = 7'b0100100;
      4'd3: dec = 7'b0110000;
      4'd4: dec = 7'b0011001;
      4'd5: dec = 7'b0010010;
      4'd6: dec = 7'b0000010;
      4'd7: dec = 7'b1111000;
      4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0010000;
      default: dec = 7'b0000110;
    endcase
  endfunction

  always_comb seg7_in = dec(bcd);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] p, input string tag);
    int n = 0;
    while (an !== p && n < 100) begin
      step();
      n++;
    end
    chk(tag, 32'(an), 32'(p));
  endtask

  task automatic show_start(input logic [3:0] p, input string tag);
    wait_an(4'b1111, "wait_blank");
    wait_an(p, tag);
  endtask

  initial begin
    logic [3:0] exp_an;
    rst = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'd0;
    #1;
    chk("rst_an", 32'(an), 32'h0E);
    chk("rst_seg7", 32'(seg7), 32'h7F);
    chk("rst_idx", 32'(scan_idx), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    step(); step();
    rst = 1'b0;

    // Scan order and dwell timing over one full period
    for (int c = 0; c < 40; c++) begin
      int pos;
      int idx;
      pos = c % 10;
      idx = c / 10;
      exp_an = (pos < 8) ? ~(4'b0001 << idx) : 4'b1111;
      chk("scan_an", 32'(an), 32'(exp_an));
      chk("scan_idx", 32'(scan_idx), 32'(idx));
      if (pos == 0 || pos >= 8) chk("scan_seg_dark", 32'(seg7), 32'h7F);
      else chk("scan_seg_zero", 32'(seg7), 32'h40);
      step();
    end
    chk("wrap_an", 32'(an), 32'h0E);
    chk("wrap_idx", 32'(scan_idx), 32'd0);

    // Digit load
    for (int i = 0; i < 4; i++) wr(2'(i), 4'(i + 1));
    for (int i = 0; i < 4; i++) begin
      exp_an = ~(4'b0001 << i);
      show_start(exp_an, "load_an");
      chk("load_bcd", 32'(bcd), 32'(i + 1));
      chk("load_seg_first", 32'(seg7), 32'h7F);
      step();
      chk("load_seg", 32'(seg7), 32'(dec(4'(i + 1))));
      chk("load_idx", 32'(scan_idx), 32'(i));
    end

    // Out-of-range digit is blanked while bcd carries the raw value
    wr(2'd2, 4'hC);
    show_start(4'b1011, "oor_an");
    chk("oor_bcd", 32'(bcd), 32'hC);
    step();
    chk("oor_seg", 32'(seg7), 32'h7F);
    step();
    chk("oor_seg2", 32'(seg7), 32'h7F);
    chk("oor_an_held", 32'(an), 32'hB);

    // Live update of the digit being shown
    show_start(4'b0111, "live_an");
    step(); step();
    chk("live_seg_old", 32'(seg7), 32'(dec(4'd4)));
    wr(2'd3, 4'd7);
    chk("live_bcd", 32'(bcd), 32'd7);
    chk("live_seg_lag", 32'(seg7), 32'(dec(4'd4)));
    chk("live_an1", 32'(an), 32'h7);
    step();
    chk("live_seg_new", 32'(seg7), 32'(dec(4'd7)));
    chk("live_an2", 32'(an), 32'h7);

    // Asynchronous reset in the middle of SHOW for digit 2
    show_start(4'b1011, "ar_an_pre");
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    chk("ar_an", 32'(an), 32'hE);
    chk("ar_idx", 32'(scan_idx), 32'd0);
    chk("ar_bcd", 32'(bcd), 32'd0);
    chk("ar_seg", 32'(seg7), 32'h7F);
    step();
    rst = 1'b0;
    show_start(4'b1011, "ar_d2_an");
    chk("ar_d2_bcd", 32'(bcd), 32'd0);
    show_start(4'b0111, "ar_d3_an");
    chk("ar_d3_bcd", 32'(bcd), 32'd0);

    // Leading-zero handling: digits {0,5,0,0} on addr 3..0
    wr(2'd2, 4'd5);
    show_start(4'b0111, "lz3_an");
    step();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    chk("lz3_seg", 32'(seg7), 32'h7F);
`else
    chk("lz3_seg", 32'(seg7), 32'(dec(4'd0)));
`endif
    chk("lz3_an_held", 32'(an), 32'h7);
    show_start(4'b1110, "lz0_an");
    step();
    chk("lz0_seg", 32'(seg7), 32'(dec(4'd0)));
    show_start(4'b1101, "lz1_an");
    step();
    chk("lz1_seg", 32'(seg7), 32'(dec(4'd0)));
    show_start(4'b1011, "lz2_an");
    step();
    chk("lz2_seg", 32'(seg7), 32'(dec(4'd5)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
